// File: rtl/q_episode_ctrl.sv
// q_episode_ctrl: epsilon-greedy Q-learning episode sequencer, 6x6 grid.
// Optional: define Q_EPS_DECAY_EN for per-episode epsilon decay.
module q_episode_ctrl #(
  parameter int unsigned MAX_STEPS    = 64,
  parameter int unsigned NUM_EPISODES = 100,
  parameter logic [7:0]  EPSILON      = 8'd26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          GOAL_REWARD  = 100,
  parameter int          STEP_REWARD  = -1,
  parameter int          WALL_REWARD  = -10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      start_state,
  input  logic [5:0]      target_state,
  input  logic [36:0]     blocked_vec,
  output logic            q_rd_en,
  output logic [5:0]      q_rd_state,
  input  logic [3:0][31:0] q_rd_data,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [5:0]      upd_state,
  output logic [1:0]      upd_action,
  output logic [5:0]      upd_next_state,
  output logic [15:0]     upd_reward,
  output logic            busy,
  output logic            done,
  output logic [5:0]      cur_state,
  output logic [7:0]      step_cnt,
  output logic [9:0]      episode_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SELECT,
    S_MOVE,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] R_GOAL = 16'(GOAL_REWARD);
  localparam logic [15:0] R_STEP = 16'(STEP_REWARD);
  localparam logic [15:0] R_WALL = 16'(WALL_REWARD);
  localparam logic [7:0]  MAX_S  = 8'(MAX_STEPS);
  localparam logic [9:0]  NUM_E  = 10'(NUM_EPISODES);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  eps_q, eps_d;
  logic [5:0]  start_q, start_d;
  logic [5:0]  tgt_q, tgt_d;
  logic [5:0]  cur_q, cur_d;
  logic [7:0]  step_q, step_d;
  logic [9:0]  ep_q, ep_d;
  logic [1:0]  act_q, act_d;
  logic [5:0]  nxt_q, nxt_d;
  logic [15:0] rew_q, rew_d;

  logic [1:0]  greedy;
  logic        lfsr_fb;
  logic        tgt_ok;
  logic [5:0]  sm1;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [5:0]  cand;
  logic        legal;
  logic [63:0] blk_ext;
  logic [5:0]  mv_nxt;
  logic [15:0] mv_rew;
  logic [7:0]  step_inc;
  logic [9:0]  ep_inc;
  logic        ep_end;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];
  assign tgt_ok  = (tgt_q != 6'd0) && (tgt_q <= 6'd36);
  assign blk_ext = {27'd0, blocked_vec};

  assign step_inc = step_q + 8'd1;
  assign ep_inc   = ep_q + 10'd1;
  assign ep_end   = (nxt_q == tgt_q && tgt_ok)
                 || (step_inc == MAX_S);

  assign upd_state      = cur_q;
  assign upd_action     = act_q;
  assign upd_next_state = nxt_q;
  assign upd_reward     = rew_q;
  assign cur_state      = cur_q;
  assign step_cnt       = step_q;
  assign episode_cnt    = ep_q;

  // Greedy pick: signed argmax over the row, lowest index wins ties.
  always_comb begin
    logic signed [31:0] bv;
    greedy = 2'd0;
    bv     = q_rd_data[0];
    for (int i = 1; i < 4; i++) begin
      if ($signed(q_rd_data[i]) > bv) begin
        greedy = 2'(i);
        bv     = q_rd_data[i];
      end
    end
  end

  // Grid move: candidate cell, legality, blocking and reward.
  always_comb begin
    sm1   = cur_q - 6'd1;
    row   = sm1 / 6'd6;
    col   = sm1 % 6'd6;
    cand  = cur_q;
    legal = 1'b0;
    unique case (act_q)
      2'd0: begin
        legal = (row != 6'd0);
        cand  = cur_q - 6'd6;
      end
      2'd1: begin
        legal = (col < 6'd5);
        cand  = cur_q + 6'd1;
      end
      2'd2: begin
        legal = (row < 6'd5);
        cand  = cur_q + 6'd6;
      end
      2'd3: begin
        legal = (col != 6'd0);
        cand  = cur_q - 6'd1;
      end
    endcase
    mv_nxt = cur_q;
    mv_rew = R_WALL;
    if (legal && !blk_ext[cand]) begin
      mv_nxt = cand;
      if (cand == tgt_q && tgt_ok) begin
        mv_rew = R_GOAL;
      end else begin
        mv_rew = R_STEP;
      end
    end
  end

  // Next-state, datapath updates and Moore outputs.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    eps_d      = eps_q;
    start_d    = start_q;
    tgt_d      = tgt_q;
    cur_d      = cur_q;
    step_d     = step_q;
    ep_d       = ep_q;
    act_d      = act_q;
    nxt_d      = nxt_q;
    rew_d      = rew_q;
    q_rd_en    = 1'b0;
    q_rd_state = 6'd0;
    upd_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_d = start_state;
          tgt_d   = target_state;
          cur_d   = start_state;
          step_d  = 8'd0;
          ep_d    = 10'd0;
          eps_d   = EPSILON;
          state_d = S_READ;
        end
      end
      S_READ: begin
        busy       = 1'b1;
        q_rd_en    = 1'b1;
        q_rd_state = cur_q;
        state_d    = S_SELECT;
      end
      S_SELECT: begin
        busy = 1'b1;
        if (lfsr_q[7:0] < eps_q) begin
          act_d = lfsr_q[9:8];
        end else begin
          act_d = greedy;
        end
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        state_d = S_MOVE;
      end
      S_MOVE: begin
        busy    = 1'b1;
        nxt_d   = mv_nxt;
        rew_d   = mv_rew;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy      = 1'b1;
        upd_valid = 1'b1;
        if (upd_ready) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy    = 1'b1;
        cur_d   = nxt_q;
        step_d  = step_inc;
        state_d = S_READ;
        if (ep_end) begin
          ep_d   = ep_inc;
          step_d = 8'd0;
          cur_d  = start_q;
`ifdef Q_EPS_DECAY_EN
          if (eps_q != 8'd0) begin
            eps_d = eps_q - 8'd1;
          end
`else
          eps_d = eps_q;
`endif
          if (ep_inc == NUM_E) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      eps_q   <= EPSILON;
      start_q <= 6'd0;
      tgt_q   <= 6'd0;
      cur_q   <= 6'd0;
      step_q  <= 8'd0;
      ep_q    <= 10'd0;
      act_q   <= 2'd0;
      nxt_q   <= 6'd0;
      rew_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      eps_q   <= eps_d;
      start_q <= start_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
      act_q   <= act_d;
      nxt_q   <= nxt_d;
      rew_q   <= rew_d;
    end
  end

endmodule

// File: tb/tb_q_episode_ctrl.sv
// tb_q_episode_ctrl: directed checks of q_episode_ctrl.
// Greedy build, 3 steps per episode, 2 episodes per run.
module tb_q_episode_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [5:0]      start_state;
  logic [5:0]      target_state;
  logic [36:0]     blocked_vec;
  logic            q_rd_en;
  logic [5:0]      q_rd_state;
  logic [3:0][31:0] q_rd_data;
  logic            upd_valid;
  logic            upd_ready;
  logic [5:0]      upd_state;
  logic [1:0]      upd_action;
  logic [5:0]      upd_next_state;
  logic [15:0]     upd_reward;
  logic            busy;
  logic            done;
  logic [5:0]      cur_state;
  logic [7:0]      step_cnt;
  logic [9:0]      episode_cnt;

  logic [3:0][31:0] qtab [0:63];
  int npass = 0;
  int ntot  = 0;

  q_episode_ctrl #(
    .MAX_STEPS(3),
    .NUM_EPISODES(2),
    .EPSILON(8'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_state(start_state),
    .target_state(target_state),
    .blocked_vec(blocked_vec),
    .q_rd_en(q_rd_en),
    .q_rd_state(q_rd_state),
    .q_rd_data(q_rd_data),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_state(upd_state),
    .upd_action(upd_action),
    .upd_next_state(upd_next_state),
    .upd_reward(upd_reward),
    .busy(busy),
    .done(done),
    .cur_state(cur_state),
    .step_cnt(step_cnt),
    .episode_cnt(episode_cnt)
  );

  always #5 clk = ~clk;

  // Q table read port: one-cycle latency, poisoned (favours W) when idle.
  always @(posedge clk) begin
    if (q_rd_en) q_rd_data <= qtab[q_rd_state];
    else q_rd_data <= {32'd9, 96'd0};
  end

  function automatic logic [3:0][31:0] qrow(
    input int n, input int e, input int s, input int w);
    return {32'(w), 32'(s), 32'(e), 32'(n)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start_run(input int s, input int t);
    start_state  = 6'(s);
    target_state = 6'(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("rd_en", 32'(q_rd_en), 32'd1);
    chk("rd_state", 32'(q_rd_state), 32'(s));
  endtask

  task automatic expect_upd(input string tag,
                            input int s, input int a,
                            input int sn, input int r,
                            input int stp, input int ep);
    int n;
    logic [15:0] rr;
    n  = 0;
    rr = 16'(r);
    while (!upd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!upd_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_s"}, 32'(upd_state), 32'(s));
    chk({tag, "_a"}, 32'(upd_action), 32'(a));
    chk({tag, "_sn"}, 32'(upd_next_state), 32'(sn));
    chk({tag, "_r"}, {16'd0, upd_reward}, {16'd0, rr});
    chk({tag, "_cur"}, 32'(cur_state), 32'(s));
    chk({tag, "_step"}, 32'(step_cnt), 32'(stp));
    chk({tag, "_ep"}, 32'(episode_cnt), 32'(ep));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int home);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_ep_cnt"}, 32'(episode_cnt), 32'd2);
    chk({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
    chk({tag, "_cur_home"}, 32'(cur_state), 32'(home));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) qtab[i] = '0;
    rst          = 1'b0;
    start        = 1'b0;
    start_state  = 6'd0;
    target_state = 6'd0;
    blocked_vec  = '0;
    upd_ready    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_rd_en", 32'(q_rd_en), 32'd0);
    chk("rst_cur", 32'(cur_state), 32'd0);
    chk("rst_ep", 32'(episode_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // All-zero Q: tie picks N, wall at the top row.
    start_run(1, 2);
    for (int ep = 0; ep < 2; ep++)
      for (int k = 0; k < 3; k++)
        expect_upd("wall_tie", 1, 0, 1, -10, k, ep);
    wait_done("A", 1);

    // East into the goal, with a stalled handshake.
    qtab[1] = qrow(0, 5, 0, 0);
    upd_ready = 1'b0;
    start_run(1, 2);
    expect_upd("goal_hold", 1, 1, 2, 100, 0, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        start = 1'b1;
        start_state = 6'd20;
        target_state = 6'd20;
      end else begin
        start = 1'b0;
      end
      chk("hold_valid", 32'(upd_valid), 32'd1);
      chk("hold_s", 32'(upd_state), 32'd1);
      chk("hold_a", 32'(upd_action), 32'd1);
      chk("hold_sn", 32'(upd_next_state), 32'd2);
      chk("hold_step", 32'(step_cnt), 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    upd_ready = 1'b1;
    @(negedge clk);
    chk("hold_consumed", 32'(upd_valid), 32'd0);
    expect_upd("goal_ep1", 1, 1, 2, 100, 0, 1);
    wait_done("B", 1);

    // South into a blocked cell.
    qtab[1] = qrow(0, 0, 9, 0);
    blocked_vec[7] = 1'b1;
    start_run(1, 2);
    for (int ep = 0; ep < 2; ep++)
      for (int k = 0; k < 3; k++)
        expect_upd("blocked", 1, 2, 1, -10, k, ep);
    wait_done("C", 1);
    blocked_vec = '0;

    // Legal S, W (signed argmax), N tie; goal on the last step.
    qtab[8]  = qrow(1, 2, 3, -4);
    qtab[14] = qrow(-5, -9, -3, 2);
    qtab[13] = qrow(7, 7, 0, 0);
    start_run(8, 7);
    for (int ep = 0; ep < 2; ep++) begin
      expect_upd("walk_s", 8, 2, 14, -1, 0, ep);
      expect_upd("walk_w", 14, 3, 13, -1, 1, ep);
      expect_upd("walk_n", 13, 0, 7, 100, 2, ep);
    end
    wait_done("D", 8);

    // East edge wall.
    qtab[6] = qrow(0, 10, 0, 0);
    start_run(6, 1);
    for (int ep = 0; ep < 2; ep++)
      for (int k = 0; k < 3; k++)
        expect_upd("east_edge", 6, 1, 6, -10, k, ep);
    wait_done("E", 6);

    // West edge wall on the bottom row.
    qtab[31] = qrow(0, 0, 5, 8);
    start_run(31, 36);
    for (int ep = 0; ep < 2; ep++)
      for (int k = 0; k < 3; k++)
        expect_upd("west_edge", 31, 3, 31, -10, k, ep);
    wait_done("F", 31);

    // Asynchronous reset while an update is pending.
    qtab[1] = qrow(0, 5, 0, 0);
    upd_ready = 1'b0;
    start_run(1, 2);
    for (int i = 0; i < 10 && !upd_valid; i++) @(negedge clk);
    chk("pre_rst_valid", 32'(upd_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(upd_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cur", 32'(cur_state), 32'd0);
    chk("arst_step", 32'(step_cnt), 32'd0);
    chk("arst_ep", 32'(episode_cnt), 32'd0);
    chk("arst_upd_s", 32'(upd_state), 32'd0);
    chk("arst_upd_sn", 32'(upd_next_state), 32'd0);
    chk("arst_upd_r", {16'd0, upd_reward}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    upd_ready = 1'b1;
    @(negedge clk);
    start_run(1, 2);
    expect_upd("post_rst0", 1, 1, 2, 100, 0, 0);
    expect_upd("post_rst1", 1, 1, 2, 100, 0, 1);
    wait_done("R", 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
